// File: rtl/fb_rd_pkg.sv
// Shared definitions for the frame-buffer read scheduler: FSM state
// encodings, the 4 KB page size and the burst-length helper.
// No ports; imported by fb_rd_burst_calc and fb_rd_scheduler.
package fb_rd_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRAIN = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_ISSUE = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // Bursts never cross a 4 KB page.
  localparam int unsigned PAGE_BYTES = 4096;
  localparam int          PAGE_OFF_W = 12;

  function automatic int unsigned f_min3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/fb_rd_burst_calc.sv
// Burst length for the next read command: min of max burst, words left in
// the line and words left before the next 4 KB page. Purely combinational.
// Ports: page_off_i (addr[11:0]), words_left_i, len_o (1..C_BURST_LEN).
module fb_rd_burst_calc
  import fb_rd_pkg::*;
#(
  parameter int C_DATA_BYTES = 32,
  parameter int C_BURST_LEN  = 16,
  parameter int C_LINE_W     = 16
) (
  input  logic [PAGE_OFF_W-1:0]        page_off_i,
  input  logic [C_LINE_W-1:0]          words_left_i,
  output logic [$clog2(C_BURST_LEN):0] len_o
);

  localparam int LEN_W = $clog2(C_BURST_LEN) + 1;

  int unsigned page_words;
  int unsigned len_full;

  always_comb begin
    page_words = (PAGE_BYTES - 32'(page_off_i)) / 32'(C_DATA_BYTES);
    len_full   = f_min3(32'(C_BURST_LEN), 32'(words_left_i), page_words);
    len_o      = LEN_W'(len_full);
  end

endmodule

// File: rtl/fb_rd_scheduler.sv
// Read-side frame-buffer DMA scheduler: per-frame geometry latch, line-by-line
// burst issue gated on FIFO space, start-of-frame flush and VS restart.
// Ports: clk_in/rst, EN_I/VS_I frame control, BASE_ADDR_I/BUF_SEL_I/LINE_*_I/
// STRIDE_I geometry, FIFO_CNT_I/DATA_VALID_I fill tracking, CMD_* burst
// command handshake, FIFO_RST_O flush pulse, BUSY_O, FRAME_DONE_O.
module fb_rd_scheduler
  import fb_rd_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_BYTES = 32,
  parameter int C_BURST_LEN  = 16,
  parameter int C_FIFO_DEPTH = 512,
  parameter int C_BUF_NUM    = 3,
  parameter int C_LINE_W     = 16
) (
  input  logic                              clk_in,
  input  logic                              rst,
  input  logic                              EN_I,
  input  logic                              VS_I,
  input  logic [C_BUF_NUM*C_ADDR_WIDTH-1:0] BASE_ADDR_I,
  input  logic [$clog2(C_BUF_NUM)-1:0]      BUF_SEL_I,
  input  logic [C_LINE_W-1:0]               LINE_WORDS_I,
  input  logic [C_LINE_W-1:0]               LINE_NUM_I,
  input  logic [C_ADDR_WIDTH-1:0]           STRIDE_I,
  input  logic [$clog2(C_FIFO_DEPTH):0]     FIFO_CNT_I,
  input  logic                              DATA_VALID_I,
  output logic                              CMD_VALID_O,
  input  logic                              CMD_READY_I,
  output logic [C_ADDR_WIDTH-1:0]           CMD_ADDR_O,
  output logic [$clog2(C_BURST_LEN):0]      CMD_LEN_O,
  output logic                              FIFO_RST_O,
  output logic                              BUSY_O,
  output logic                              FRAME_DONE_O
);

  localparam int CNT_W = $clog2(C_FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int LEN_W = $clog2(C_BURST_LEN) + 1;

  logic [2:0]              state_q, state_d;
  logic                    vs_q;
  logic [CNT_W-1:0]        out_q, out_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d, line_addr_q, line_addr_d;
  logic [C_ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [C_LINE_W-1:0]     words_left_q, words_left_d, line_words_q, line_words_d;
  logic [C_LINE_W-1:0]     lines_left_q, lines_left_d;
  logic                    restart_q, restart_d, restart_en_q, restart_en_d;

  logic                    vs_edge, accept, space_ok;
  logic [C_ADDR_WIDTH-1:0] base_sel, burst_bytes;
  logic [C_LINE_W-1:0]     words_rem, calc_words;
  logic [PAGE_OFF_W-1:0]   calc_off;
  logic [LEN_W-1:0]        len;
  logic [SUM_W-1:0]        out_sum;

  assign vs_edge  = VS_I & ~vs_q;
  assign base_sel = BASE_ADDR_I[int'(BUF_SEL_I)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
  assign accept   = (state_q == ST_ISSUE) && CMD_READY_I;

  // In LATCH the length is computed straight from the values being captured,
  // so the space check can run there and the first command appears one cycle
  // earlier than going through WAIT.
  assign calc_off   = (state_q == ST_LATCH) ? base_sel[PAGE_OFF_W-1:0] : addr_q[PAGE_OFF_W-1:0];
  assign calc_words = (state_q == ST_LATCH) ? LINE_WORDS_I : words_left_q;

  fb_rd_burst_calc #(
    .C_DATA_BYTES (C_DATA_BYTES),
    .C_BURST_LEN  (C_BURST_LEN),
    .C_LINE_W     (C_LINE_W)
  ) u_burst_calc (
    .page_off_i   (calc_off),
    .words_left_i (calc_words),
    .len_o        (len)
  );

  assign space_ok    = (SUM_W'(FIFO_CNT_I) + SUM_W'(out_q) + SUM_W'(len)) <= SUM_W'(C_FIFO_DEPTH);
  assign burst_bytes = C_ADDR_WIDTH'(len) * C_ADDR_WIDTH'(C_DATA_BYTES);
  assign words_rem   = words_left_q - C_LINE_W'(len);

  // Outstanding words: +len on accept, -1 per returned word, floor at 0.
  always_comb begin
    out_sum = SUM_W'(out_q) + (accept ? SUM_W'(len) : '0);
    if (DATA_VALID_I && (out_sum != '0)) out_sum = out_sum - SUM_W'(1);
    out_d = CNT_W'(out_sum);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    line_addr_d  = line_addr_q;
    stride_d     = stride_q;
    words_left_d = words_left_q;
    line_words_d = line_words_q;
    lines_left_d = lines_left_q;
    restart_d    = restart_q;
    restart_en_d = restart_en_q;
    case (state_q)
      ST_IDLE:  if (vs_edge && EN_I) state_d = ST_DRAIN;
      // CMD_VALID_O is structurally low here; only returned data can block.
      ST_DRAIN: if (out_q == '0) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_LATCH;
      ST_LATCH: begin
        addr_d       = base_sel;
        line_addr_d  = base_sel;
        stride_d     = STRIDE_I;
        words_left_d = LINE_WORDS_I;
        line_words_d = LINE_WORDS_I;
        lines_left_d = LINE_NUM_I;
        if (vs_edge)       state_d = EN_I ? ST_DRAIN : ST_IDLE;
        else if (space_ok) state_d = ST_ISSUE;
        else               state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (vs_edge)       state_d = EN_I ? ST_DRAIN : ST_IDLE;
        else if (space_ok) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A VS seen while the command is pending is remembered until the
        // handshake completes; the command is never withdrawn.
        if (vs_edge && !accept) begin
          restart_d    = 1'b1;
          restart_en_d = EN_I;
        end
        if (accept) begin
          addr_d       = addr_q + burst_bytes;
          words_left_d = words_rem;
          state_d      = ST_WAIT;
          if (words_rem == '0) begin
            line_addr_d  = line_addr_q + stride_q;
            addr_d       = line_addr_q + stride_q;
            lines_left_d = lines_left_q - C_LINE_W'(1);
            words_left_d = line_words_q;
            if (lines_left_q == C_LINE_W'(1)) state_d = ST_DONE;
          end
          restart_d = 1'b0;
          if (vs_edge)        state_d = EN_I ? ST_DRAIN : ST_IDLE;
          else if (restart_q) state_d = restart_en_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DONE:  state_d = (vs_edge && EN_I) ? ST_DRAIN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vs_q         <= 1'b1;  // VS already high out of reset is not an edge
      out_q        <= '0;
      addr_q       <= '0;
      line_addr_q  <= '0;
      stride_q     <= '0;
      words_left_q <= '0;
      line_words_q <= '0;
      lines_left_q <= '0;
      restart_q    <= 1'b0;
      restart_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= VS_I;
      out_q        <= out_d;
      addr_q       <= addr_d;
      line_addr_q  <= line_addr_d;
      stride_q     <= stride_d;
      words_left_q <= words_left_d;
      line_words_q <= line_words_d;
      lines_left_q <= lines_left_d;
      restart_q    <= restart_d;
      restart_en_q <= restart_en_d;
    end
  end

  assign CMD_VALID_O  = (state_q == ST_ISSUE);
  assign CMD_ADDR_O   = CMD_VALID_O ? addr_q : '0;
  assign CMD_LEN_O    = CMD_VALID_O ? len : '0;
  assign FIFO_RST_O   = (state_q == ST_FLUSH);
  assign BUSY_O       = (state_q == ST_LATCH) || (state_q == ST_WAIT) ||
                        (state_q == ST_ISSUE) || (state_q == ST_DONE);
  assign FRAME_DONE_O = (state_q == ST_DONE);

endmodule

// File: tb/tb_fb_rd_scheduler.sv
// Directed bench for fb_rd_scheduler with a simple memory/FIFO model:
// words return 4 cycles after accept, FIFO drains one word per cycle.
module tb_fb_rd_scheduler;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        EN_I, VS_I;
  logic [95:0] BASE_ADDR_I;
  logic [1:0]  BUF_SEL_I;
  logic [15:0] LINE_WORDS_I, LINE_NUM_I;
  logic [31:0] STRIDE_I;
  logic [9:0]  FIFO_CNT_I;
  logic        DATA_VALID_I;
  logic        CMD_VALID_O, CMD_READY_I;
  logic [31:0] CMD_ADDR_O;
  logic [4:0]  CMD_LEN_O;
  logic        FIFO_RST_O, BUSY_O, FRAME_DONE_O;

  fb_rd_scheduler dut (
    .clk_in(clk_in), .rst(rst), .EN_I(EN_I), .VS_I(VS_I),
    .BASE_ADDR_I(BASE_ADDR_I), .BUF_SEL_I(BUF_SEL_I),
    .LINE_WORDS_I(LINE_WORDS_I), .LINE_NUM_I(LINE_NUM_I), .STRIDE_I(STRIDE_I),
    .FIFO_CNT_I(FIFO_CNT_I), .DATA_VALID_I(DATA_VALID_I),
    .CMD_VALID_O(CMD_VALID_O), .CMD_READY_I(CMD_READY_I),
    .CMD_ADDR_O(CMD_ADDR_O), .CMD_LEN_O(CMD_LEN_O),
    .FIFO_RST_O(FIFO_RST_O), .BUSY_O(BUSY_O), .FRAME_DONE_O(FRAME_DONE_O)
  );

  always #5 clk_in = ~clk_in;

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, vs_cyc = 0, first_rst = -1, first_vld = -1;
  int          rst_cnt = 0, done_cnt = 0, fifo_cnt = 0, last_t = 0;
  bit          busy_seen = 0, mem_en = 1, fifo_auto = 1;
  logic [31:0] log_a [$];
  int          log_l [$];
  int          dq [$];
  int          exp_a [0:5];
  int          exp_l [0:5];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe the cycle's outputs, advance one clock, then drive the model inputs.
  task automatic tick();
    if (CMD_VALID_O && CMD_READY_I) begin
      log_a.push_back(CMD_ADDR_O);
      log_l.push_back(int'(CMD_LEN_O));
      if (mem_en)
        for (int w = 0; w < int'(CMD_LEN_O); w++) begin
          if (last_t + 1 > cyc + 5) last_t = last_t + 1;
          else                      last_t = cyc + 5;
          dq.push_back(last_t);
        end
    end
    if (FIFO_RST_O) begin rst_cnt++; if (first_rst < 0) first_rst = cyc; end
    if (CMD_VALID_O && first_vld < 0) first_vld = cyc;
    if (FRAME_DONE_O) done_cnt++;
    if (BUSY_O) busy_seen = 1;
    if (FIFO_RST_O) fifo_cnt = 0;
    else fifo_cnt = fifo_cnt + (DATA_VALID_I ? 1 : 0) - (fifo_cnt > 0 ? 1 : 0);
    @(posedge clk_in);
    #1;
    cyc++;
    if (mem_en) begin
      if (dq.size() > 0 && dq[0] == cyc + 1) begin
        DATA_VALID_I = 1'b1;
        void'(dq.pop_front());
      end else DATA_VALID_I = 1'b0;
    end
    if (fifo_auto) FIFO_CNT_I = 10'(fifo_cnt);
  endtask

  task automatic start_frame();
    VS_I = 1'b1; vs_cyc = cyc; first_rst = -1; first_vld = -1;
    tick(); tick();
    VS_I = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int k;
    k = 0;
    while (!CMD_VALID_O && k < 200) begin tick(); k++; end
    check_val(tag, (k >= 200), 0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((BUSY_O || dq.size() != 0) && k < 3000) begin tick(); k++; end
    check_val(tag, (k >= 3000), 0);
    repeat (8) tick();
  endtask

  initial begin
    int n0, r0, d0;
    exp_a[0] = 32'h1000; exp_a[1] = 32'h1200; exp_a[2] = 32'h1400;
    exp_a[3] = 32'h1800; exp_a[4] = 32'h1A00; exp_a[5] = 32'h1C00;
    exp_l[0] = 16; exp_l[1] = 16; exp_l[2] = 8;
    exp_l[3] = 16; exp_l[4] = 16; exp_l[5] = 8;

    rst = 1'b1; EN_I = 1'b1; VS_I = 1'b0; BUF_SEL_I = 2'd0;
    BASE_ADDR_I = {32'h0003_0000, 32'h0000_0F80, 32'h0000_1000};
    LINE_WORDS_I = 16'd40; LINE_NUM_I = 16'd2; STRIDE_I = 32'h800;
    FIFO_CNT_I = '0; DATA_VALID_I = 1'b0; CMD_READY_I = 1'b1;
    repeat (3) tick();
    check_val("rst_valid", CMD_VALID_O, 0);
    check_val("rst_addr",  CMD_ADDR_O, 0);
    check_val("rst_len",   CMD_LEN_O, 0);
    check_val("rst_fiforst", FIFO_RST_O, 0);
    check_val("rst_busy",  BUSY_O, 0);
    check_val("rst_done",  FRAME_DONE_O, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic two-line frame.
    start_frame();
    wait_vld("basic_vld_timeout");
    wait_idle("basic_idle_timeout");
    check_val("basic_rst_lat", first_rst - vs_cyc, 2);
    check_val("basic_vld_lat", first_vld - vs_cyc, 4);
    check_val("basic_ncmd", log_a.size(), 6);
    for (int i = 0; i < 6 && i < log_a.size(); i++) begin
      check_val($sformatf("basic_addr%0d", i), log_a[i], exp_a[i]);
      check_val($sformatf("basic_len%0d", i),  log_l[i], exp_l[i]);
    end
    check_val("basic_done_cnt", done_cnt, 1);
    check_val("basic_rst_cnt",  rst_cnt, 1);

    // 4 KB page split.
    BUF_SEL_I = 2'd1; LINE_WORDS_I = 16'd16; LINE_NUM_I = 16'd1;
    n0 = log_a.size();
    start_frame();
    wait_vld("split_vld_timeout");
    wait_idle("split_idle_timeout");
    check_val("split_ncmd", log_a.size() - n0, 2);
    if (log_a.size() >= n0 + 2) begin
      check_val("split_addr0", log_a[n0], 32'h0F80);
      check_val("split_len0",  log_l[n0], 4);
      check_val("split_addr1", log_a[n0+1], 32'h1000);
      check_val("split_len1",  log_l[n0+1], 12);
    end

    // FIFO space back-pressure.
    BUF_SEL_I = 2'd0; fifo_auto = 0; FIFO_CNT_I = 10'd500;
    n0 = log_a.size();
    start_frame();
    repeat (12) tick();
    check_val("bp_no_cmd", log_a.size() - n0, 0);
    check_val("bp_valid_low", CMD_VALID_O, 0);
    check_val("bp_busy", BUSY_O, 1);
    FIFO_CNT_I = 10'd496;
    tick();
    check_val("bp_valid_high", CMD_VALID_O, 1);
    check_val("bp_len", CMD_LEN_O, 16);
    fifo_auto = 1;
    wait_idle("bp_idle_timeout");

    // Command held stable under CMD_READY_I low.
    CMD_READY_I = 1'b0; d0 = done_cnt;
    n0 = log_a.size();
    start_frame();
    wait_vld("hold_vld_timeout");
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("hold_valid%0d", i), CMD_VALID_O, 1);
      check_val($sformatf("hold_addr%0d", i),  CMD_ADDR_O, 32'h1000);
      check_val($sformatf("hold_len%0d", i),   CMD_LEN_O, 16);
      tick();
    end
    CMD_READY_I = 1'b1;
    tick();
    CMD_READY_I = 1'b0;
    repeat (3) tick();
    check_val("hold_accepts", log_a.size() - n0, 1);
    check_val("hold_valid_after", CMD_VALID_O, 0);
    CMD_READY_I = 1'b1;
    wait_idle("hold_idle_timeout");
    check_val("hold_done", done_cnt - d0, 1);

    // Mid-frame VS with 32 words outstanding.
    mem_en = 0; LINE_WORDS_I = 16'd64; LINE_NUM_I = 16'd4;
    n0 = log_a.size(); d0 = done_cnt;
    start_frame();
    begin
      int k;
      k = 0;
      while (log_a.size() < n0 + 2 && k < 200) begin tick(); k++; end
      check_val("mid_two_cmds_timeout", (k >= 200), 0);
    end
    r0 = rst_cnt;
    VS_I = 1'b1; BUF_SEL_I = 2'd2; first_vld = -1;
    tick(); tick();
    VS_I = 1'b0;
    repeat (8) tick();
    check_val("mid_no_cmd", log_a.size() - n0, 2);
    check_val("mid_valid_low", CMD_VALID_O, 0);
    for (int i = 0; i < 32; i++) begin DATA_VALID_I = 1'b1; tick(); end
    DATA_VALID_I = 1'b0;
    check_val("mid_no_flush_during_drain", rst_cnt - r0, 0);
    check_val("mid_no_cmd_during_drain", log_a.size() - n0, 2);
    mem_en = 1;
    wait_vld("mid_vld_timeout");
    check_val("mid_one_flush", rst_cnt - r0, 1);
    check_val("mid_new_addr", CMD_ADDR_O, 32'h0003_0000);
    check_val("mid_new_len", CMD_LEN_O, 16);
    check_val("mid_no_done", done_cnt - d0, 0);
    wait_idle("mid_idle_timeout");
    check_val("mid_done_new_frame", done_cnt - d0, 1);

    // VS with EN_I low.
    EN_I = 1'b0; r0 = rst_cnt; n0 = log_a.size(); busy_seen = 0;
    start_frame();
    repeat (10) tick();
    check_val("en0_no_flush", rst_cnt - r0, 0);
    check_val("en0_no_cmd", log_a.size() - n0, 0);
    check_val("en0_not_busy", busy_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
